seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scheduler for the board's 8-digit common-anode 7-segment display. It shares one segment bus (`seg_o`, `dp_o`) among eight digit anodes (`an_o`) on a fixed round-robin slot schedule, with blanking at each slot start to prevent ghosting. It decodes one hex nibble per digit. Display content is double-buffered: a load is held pending and committed only at a frame boundary, so a frame never mixes old and new data. It sits between the user datapath (counters, switch logic) and the top-level `HEX`/`DP`/`AN` pins.

## Interface

Parameters:
- `DIV`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK`, default 500: blanking cycles at the start of each slot. Must satisfy 0 ≤ `BLANK` < `DIV`.

Ports:
- `clk`: input, 1 bit. Clock.
- `reset`: input, 1 bit. Reset, synchronous, active-low.
- `data_i`: input, 32 bits. Eight hex nibbles; digit d shows `data_i[4d+3:4d]`.
- `en_i`: input, 8 bits. Digit enable; bit d = 1 lights digit d.
- `dp_i`: input, 8 bits. Decimal point; bit d = 1 lights the point of digit d.
- `load_i`: input, 1 bit. Strobe; captures `data_i`/`en_i`/`dp_i` into the pending buffer.
- `seg_o`: output, 7 bits. Segments, active-low; bit0 = a … bit6 = g.
- `dp_o`: output, 1 bit. Decimal point, active-low.
- `an_o`: output, 8 bits. Anodes, active-low; bit d selects digit d.
- `frame_o`: output, 1 bit. One-cycle pulse on the first cycle of every frame.
- `pending_o`: output, 1 bit. High while a loaded value awaits commit.

## Operation

- **Registers:**
  - Slot counter `cnt` runs 0..`DIV`-1. Digit index `idx` runs 0..7 and increments when `cnt` wraps; 7 wraps to 0.
  - Frame length is 8·`DIV` cycles.
  - Active buffer (data/en/dp) drives the display.
  - Pending buffer holds the pending data/en/dp plus a pend flag.
- **Reset (`reset` = 0 at an edge):**
  - `cnt` = 0, `idx` = 0, active and pending buffers = 0, pend = 0.
  - Outputs: `an_o` = 8'hFF, `seg_o` = 7'h7F, `dp_o` = 1, `frame_o` = 0, `pending_o` = 0.
  - Reset mid-frame or mid-pending discards everything; there is no partial commit.
- **Slot output at position (`idx`, `cnt`):**
  - If `cnt` < `BLANK`, or active en[`idx`] = 0: `an_o` = 8'hFF, `seg_o` = 7'h7F, `dp_o` = 1.
  - Otherwise: `an_o` = ~(1 << `idx`), `seg_o` = decode(active nibble `idx`), `dp_o` = ~active dp[`idx`].
- **Decode, active-low:**
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
- **Load:** `load_i` = 1 at an edge copies the inputs into the pending buffer and sets pend.
  - A second load before commit overwrites the pending buffer; the last load wins.
- **Commit:** at the edge ending the last cycle of a frame (`idx` = 7, `cnt` = `DIV`-1), if pend = 1, active ← pending and pend is cleared.
  - If `load_i` = 1 on that same edge, the load data bypasses straight into active and pend ends at 0.
- **Guarantee:** active content never changes except at a frame boundary.

## Timing

- Outputs are registered. Cycle 0 is the first cycle after the edge where `reset` is sampled high.
- Observed output at cycle n reflects slot position `idx` = (n / `DIV`) mod 8, `cnt` = n mod `DIV`.
- `frame_o` = 1 at cycles n ≡ 0 mod 8·`DIV`, including cycle 0.
- Load-to-display latency:
  - Load on the edge ending cycle k (k in frame F): new content visible from the first cycle of frame F+1.
  - Load on the edge ending a frame's last cycle: visible the very next cycle.
- `pending_o` is high from the cycle after the load through the last cycle of the frame, and low from the frame's first cycle.
- After reset, the display is dark (active en = 0) until the first commit.

## Test plan

All scenarios use `DIV`=4, `BLANK`=1.

- **Reset values:** hold `reset`=0 for 3 cycles → `an_o`=FF, `seg_o`=7F, `dp_o`=1, `pending_o`=0. Release → `frame_o`=1 at cycle 0; `an_o`=FF for all of frame 0.
- **Basic scan:** load `data_i`=32'h0123_89AF, `en_i`=FF, `dp_i`=01 during cycle 2.
  - `pending_o`=1 in cycles 3..31.
  - Frame 1, slot 0 (cycles 32..35): cycle 32 blank (`an_o`=FF); cycles 33–35 `an_o`=FE, `seg_o`=0E, `dp_o`=0.
  - Slot 1: `an_o`=FD, `seg_o`=08, `dp_o`=1.
  - Slot 7: `an_o`=7F, `seg_o`=40.
- **Digit masking:** `en_i`=8'h0F committed → digits 4–7 show `an_o`=FF, `seg_o`=7F for their whole slot; digits 0–3 light normally.
- **Last-load-wins:** load 32'h1111_1111 at cycle 5, then 32'h2222_2222 at cycle 9 → frame 1 shows only 2 (`seg_o`=24) on all lit slots; 1 never appears.
- **Boundary bypass:** load 32'h7777_7777 during cycle 31 (`idx`=7, `cnt`=3).
  - Cycle 33 shows `seg_o`=78.
  - `pending_o` stays 0 at cycle 32.
- **Reset mid-pending:** load at cycle 10, assert reset at cycle 20 → after release, `pending_o`=0 and the display stays dark through frame 1.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: round-robin scan driver for an 8-digit common-anode
// 7-segment display. One shared segment bus, per-slot blanking against
// ghosting, hex decode, and a double-buffered load that only commits on a
// frame boundary so a frame never shows a mix of old and new content.
module seg7_scan_ctrl #(
    parameter int DIV   = 50000,  // clock cycles per digit slot (>= 2)
    parameter int BLANK = 500     // dark cycles at the start of each slot (< DIV)
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active-low
    input  logic [31:0] data_i,
    input  logic [7:0]  en_i,
    input  logic [7:0]  dp_i,
    input  logic        load_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [7:0]  an_o,
    output logic        frame_o,
    output logic        pending_o
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);

    // Slot position of the cycle currently on the pins. run_q is low only
    // while in reset, so the first released edge lands exactly on (0,0).
    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          frame_end;

    // Active (displayed) and pending (loaded, not yet committed) buffers.
    logic [31:0] act_data_q, act_data_d;
    logic [7:0]  act_en_q,   act_en_d;
    logic [7:0]  act_dp_q,   act_dp_d;
    logic [31:0] pnd_data_q, pnd_data_d;
    logic [7:0]  pnd_en_q,   pnd_en_d;
    logic [7:0]  pnd_dp_q,   pnd_dp_d;
    logic        pend_q,     pend_d;

    // Registered pin values.
    logic [7:0] an_q,    an_d;
    logic [6:0] seg_q,   seg_d;
    logic       dp_q,    dp_d;
    logic       frame_q, frame_d;
    logic       lit;

    // Active-low hex decode, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h40;
            4'h1:    hex_decode = 7'h79;
            4'h2:    hex_decode = 7'h24;
            4'h3:    hex_decode = 7'h30;
            4'h4:    hex_decode = 7'h19;
            4'h5:    hex_decode = 7'h12;
            4'h6:    hex_decode = 7'h02;
            4'h7:    hex_decode = 7'h78;
            4'h8:    hex_decode = 7'h00;
            4'h9:    hex_decode = 7'h10;
            4'hA:    hex_decode = 7'h08;
            4'hB:    hex_decode = 7'h03;
            4'hC:    hex_decode = 7'h46;
            4'hD:    hex_decode = 7'h21;
            4'hE:    hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    // Advance the slot counter and digit index; detect the frame's last cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        run_d = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
                idx_d = idx_q;
            end
        end
        frame_end = run_q && (idx_q == 3'd7) && (cnt_q == CNT_LAST);
    end

    // Load into pending; commit at the frame boundary, with a same-edge load
    // bypassing straight into the active buffer.
    always_comb begin
        act_data_d = act_data_q;
        act_en_d   = act_en_q;
        act_dp_d   = act_dp_q;
        pnd_data_d = pnd_data_q;
        pnd_en_d   = pnd_en_q;
        pnd_dp_d   = pnd_dp_q;
        pend_d     = pend_q;
        if (frame_end && load_i) begin
            act_data_d = data_i;
            act_en_d   = en_i;
            act_dp_d   = dp_i;
            pend_d     = 1'b0;
        end else if (frame_end && pend_q) begin
            act_data_d = pnd_data_q;
            act_en_d   = pnd_en_q;
            act_dp_d   = pnd_dp_q;
            pend_d     = 1'b0;
        end else if (load_i) begin
            pnd_data_d = data_i;
            pnd_en_d   = en_i;
            pnd_dp_d   = dp_i;
            pend_d     = 1'b1;
        end
    end

    // Pin values for the next cycle, from its slot position and the active
    // buffer as it will stand after this edge (so a commit shows at once).
    always_comb begin
        lit     = act_en_d[idx_d] && !(int'(cnt_d) < BLANK);
        an_d    = 8'hFF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        frame_d = (cnt_d == '0) && (idx_d == 3'd0);
        if (lit) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = hex_decode(act_data_d[idx_d*4 +: 4]);
            dp_d  = ~act_dp_d[idx_d];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            // NOTE: the data buffers are reset too, since the display must
            // come up dark and a reset must discard any pending load.
            run_q      <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            act_data_q <= '0;
            act_en_q   <= '0;
            act_dp_q   <= '0;
            pnd_data_q <= '0;
            pnd_en_q   <= '0;
            pnd_dp_q   <= '0;
            pend_q     <= 1'b0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_en_q   <= act_en_d;
            act_dp_q   <= act_dp_d;
            pnd_data_q <= pnd_data_d;
            pnd_en_q   <= pnd_en_d;
            pnd_dp_q   <= pnd_dp_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign an_o      = an_q;
    assign seg_o     = seg_q;
    assign dp_o      = dp_q;
    assign frame_o   = frame_q;
    assign pending_o = pend_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIV=4, BLANK=1. Stimulus pushes
// hand-computed expected pin values tagged with the cycle they belong to;
// a monitor on the falling edge pops and compares them as cycles go by.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_i = '0;
    logic [7:0]  en_i = '0;
    logic [7:0]  dp_i = '0;
    logic        load_i = 1'b0;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [7:0]  an_o;
    logic        frame_o;
    logic        pending_o;

    seg7_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_i),
        .en_i     (en_i),
        .dp_i     (dp_i),
        .load_i   (load_i),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .an_o     (an_o),
        .frame_o  (frame_o),
        .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
        logic       pd;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = -2;   // -1 while in reset, 0 on the first released cycle

    always @(posedge clk) begin
        if (!reset) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    function automatic void ex(input int c, input logic [7:0] an, input logic [6:0] seg,
                               input logic dp, input logic fr, input logic pd, input string nm);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.fr = fr; e.pd = pd; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic void dark(input int c, input logic fr, input logic pd, input string nm);
        ex(c, 8'hFF, 7'h7F, 1'b1, fr, pd, nm);
    endfunction

    task automatic check(input string nm, input int c, input logic [17:0] got, input logic [17:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got {an,seg,dp,frame,pend}=%h want %h", nm, c, got, want);
    endtask

    // Monitor: compare the queue head when its cycle comes up; flag skipped ones.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].cyc == cyc) begin
                check(sb[0].name, cyc, {an_o, seg_o, dp_o, frame_o, pending_o},
                      {sb[0].an, sb[0].seg, sb[0].dp, sb[0].fr, sb[0].pd});
                void'(sb.pop_front());
            end else if (sb[0].cyc >= 0 && sb[0].cyc < cyc) begin
                n_checks++;
                $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", sb[0].name, sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc != n && guard < 500);
        if (cyc != n) begin
            n_checks++;
            $display("FAIL wait_cyc timeout: got cyc=%0d want %0d", cyc, n);
        end
    endtask

    task automatic do_reset();
        dark(-1, 1'b0, 1'b0, "reset_vals");
        reset  = 1'b0;
        load_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_at(input int n, input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
        wait_cyc(n);
        data_i = d; en_i = en; dp_i = dp; load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic end_scn(input int last);
        wait_cyc(last + 1);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s never observed (cyc=%0d)", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values and basic scan.
        do_reset();
        dark(0, 1, 0, "c0_frame");    dark(1, 0, 0, "f0_dark");
        dark(2, 0, 0, "pre_load");    dark(3, 0, 1, "pend_set");
        dark(17, 0, 1, "pend_mid");   dark(31, 0, 1, "pend_last");
        dark(32, 1, 0, "f1_blank");
        ex(33, 8'hFE, 7'h0E, 0, 0, 0, "s0_F_dp");
        ex(35, 8'hFE, 7'h0E, 0, 0, 0, "s0_end");
        dark(36, 0, 0, "s1_blank");
        ex(37, 8'hFD, 7'h08, 1, 0, 0, "s1_A");
        ex(41, 8'hFB, 7'h10, 1, 0, 0, "s2_9");
        ex(45, 8'hF7, 7'h00, 1, 0, 0, "s3_8");
        ex(49, 8'hEF, 7'h30, 1, 0, 0, "s4_3");
        ex(53, 8'hDF, 7'h24, 1, 0, 0, "s5_2");
        ex(57, 8'hBF, 7'h79, 1, 0, 0, "s6_1");
        ex(61, 8'h7F, 7'h40, 1, 0, 0, "s7_0");
        ex(63, 8'h7F, 7'h40, 1, 0, 0, "s7_end");
        dark(64, 1, 0, "f2_blank");
        load_at(2, 32'h0123_89AF, 8'hFF, 8'h01);
        end_scn(64);

        // Digit masking.
        do_reset();
        ex(33, 8'hFE, 7'h0E, 1, 0, 0, "mask_d0");
        ex(37, 8'hFD, 7'h08, 1, 0, 0, "mask_d1");
        ex(45, 8'hF7, 7'h00, 1, 0, 0, "mask_d3");
        dark(49, 0, 0, "mask_d4a"); dark(51, 0, 0, "mask_d4b");
        dark(53, 0, 0, "mask_d5");  dark(57, 0, 0, "mask_d6");
        dark(61, 0, 0, "mask_d7");  dark(63, 0, 0, "mask_d7e");
        load_at(2, 32'h0123_89AF, 8'h0F, 8'h00);
        end_scn(63);

        // Last load wins.
        do_reset();
        dark(6, 0, 1, "llw_pend1"); dark(10, 0, 1, "llw_pend2");
        dark(31, 0, 1, "llw_last"); dark(32, 1, 0, "llw_frame");
        for (int s = 0; s < 8; s++) begin
            ex(33 + 4*s, ~(8'd1 << s), 7'h24, 1, 0, 0, "llw_lit");
            ex(35 + 4*s, ~(8'd1 << s), 7'h24, 1, 0, 0, "llw_end");
        end
        load_at(5, 32'h1111_1111, 8'hFF, 8'h00);
        load_at(9, 32'h2222_2222, 8'hFF, 8'h00);
        end_scn(63);

        // Load on the frame's last cycle bypasses into the active buffer.
        do_reset();
        dark(30, 0, 0, "byp_pre");  dark(31, 0, 0, "byp_edge");
        dark(32, 1, 0, "byp_nopend");
        ex(33, 8'hFE, 7'h78, 1, 0, 0, "byp_s0");
        ex(61, 8'h7F, 7'h78, 1, 0, 0, "byp_s7");
        load_at(31, 32'h7777_7777, 8'hFF, 8'h00);
        end_scn(61);

        // Reset while a load is pending discards it.
        do_reset();
        dark(11, 0, 1, "rp_pend");
        dark(-1, 0, 0, "rp_reset");
        dark(0, 1, 0, "rp_c0");     dark(5, 0, 0, "rp_f0");
        dark(32, 1, 0, "rp_f1");    dark(33, 0, 0, "rp_s0");
        dark(49, 0, 0, "rp_s4");    dark(61, 0, 0, "rp_s7");
        dark(63, 0, 0, "rp_end");
        load_at(10, 32'h8888_8888, 8'hFF, 8'hFF);
        wait_cyc(20);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        end_scn(63);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
